dmem_lsu: RTL and testbench

- Parametrised successor to the single-cycle data memory. Byte-addressed RV32 data memory with a valid/ready request/response handshake and configurable wait states.
- Performs RV32I load/store sizing from funct3 internally: byte-lane masking, alignment, sign/zero extension.
- Flags misaligned, out-of-range and illegal accesses with an error response.
- Sits between the core's MEM stage and the memory array; the core stalls on req_ready/rsp_valid.

---
 rtl/dmem_lsu_if.sv | 28 ++
 rtl/dmem_lsu.sv | 163 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
`default_nettype none
// ============================================================================
// dmem_lsu_if : request/response bus between the core MEM stage and dmem_lsu
// Rev 1.0
// ============================================================================
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// dmem_lsu : RV32 data memory with valid/ready handshake and wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault.
// Rev 1.0
// ============================================================================
module dmem_lsu #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.slave  bus
);

  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  LAST_WAIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_err;
  logic [31:0] mem [MEM_WORDS];

  logic [31:0]      w_off;
  logic [29:0]      w_word;
  logic [1:0]       w_lane, w_lane_eff;
  logic             w_byte, w_half, w_full;
  logic             w_f3_err, w_mis_err, w_range_err, w_err;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rword, w_load, w_wd;
  logic [3:0]       w_be;
  logic [7:0]       w_b;
  logic [15:0]      w_h;

  assign w_off       = r_addr - BASE_ADDR;
  assign w_word      = w_off[31:2];
  assign w_lane      = w_off[1:0];
  assign w_range_err = (r_addr < BASE_ADDR) || ({2'b00, w_word} >= MEM_WORDS);
  assign w_idx       = w_word[IDX_W-1:0];
  assign w_rword     = mem[w_idx];

  always_comb begin
    w_byte   = 1'b0;
    w_half   = 1'b0;
    w_full   = 1'b0;
    w_f3_err = 1'b0;
    if (r_we) begin
      case (r_funct3)
        3'd0:    w_byte   = 1'b1;
        3'd1:    w_half   = 1'b1;
        3'd2:    w_full   = 1'b1;
        default: w_f3_err = 1'b1;
      endcase
    end else begin
      case (r_funct3)
        3'd0, 3'd4: w_byte   = 1'b1;
        3'd1, 3'd5: w_half   = 1'b1;
        3'd2:       w_full   = 1'b1;
        default:    w_f3_err = 1'b1;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis_err  = (w_half && w_lane[0]) || (w_full && (w_lane != 2'd0));
  assign w_lane_eff = w_lane;
`else
  // Without trapping, the low address bits snap to natural alignment.
  assign w_mis_err  = 1'b0;
  assign w_lane_eff = w_full ? 2'd0 : (w_half ? {w_lane[1], 1'b0} : w_lane);
`endif

  assign w_err = w_range_err || w_f3_err || w_mis_err;

  always_comb begin
    w_be   = 4'b0000;
    w_wd   = r_wdata;
    w_load = w_rword;
    w_b    = w_rword[{w_lane_eff, 3'b000} +: 8];
    w_h    = w_lane_eff[1] ? w_rword[31:16] : w_rword[15:0];
    if (w_byte) begin
      w_be   = 4'b0001 << w_lane_eff;
      w_wd   = {4{r_wdata[7:0]}};
      w_load = {{24{w_b[7] & ~r_funct3[2]}}, w_b};
    end else if (w_half) begin
      w_be   = w_lane_eff[1] ? 4'b1100 : 4'b0011;
      w_wd   = {2{r_wdata[15:0]}};
      w_load = {{16{w_h[15] & ~r_funct3[2]}}, w_h};
    end else if (w_full) begin
      w_be   = 4'b1111;
    end
  end

  // Array has no reset; a store only lands in EXEC, which reset leaves at once.
  always_ff @(posedge clk) begin
    if (r_state == S_EXEC && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.req_valid) w_next = (WAIT_STATES != 0) ? S_WAIT : S_EXEC;
      S_WAIT: if (r_cnt == LAST_WAIT) w_next = S_EXEC;
      S_EXEC: w_next = S_RESP;
      S_RESP: if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_cnt    <= 4'd0;
          end
        end
        S_WAIT: r_cnt <= r_cnt + 4'd1;
        S_EXEC: begin
          r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
          r_err   <= w_err;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = rst && (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// tb_dmem_lsu : randomized bench for dmem_lsu against a byte-array model
// Rev 1.0
// ============================================================================
module tb_dmem_lsu;

  localparam int          MW    = 64;
  localparam int          WS0   = 0;
  localparam int          WS1   = 3;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_lsu_if bus0 ();
  dmem_lsu_if bus1 ();

  dmem_lsu #(.MEM_WORDS(MW), .WAIT_STATES(WS0), .BASE_ADDR(BASE0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_lsu #(.MEM_WORDS(MW), .WAIT_STATES(WS1), .BASE_ADDR(BASE1))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic        req_valid_a [2];
  logic        req_we_a    [2];
  logic [2:0]  req_f3_a    [2];
  logic [31:0] req_addr_a  [2];
  logic [31:0] req_wdata_a [2];
  logic        rsp_ready_a [2];
  logic        req_ready_a [2];
  logic        rsp_valid_a [2];
  logic        rsp_err_a   [2];
  logic [31:0] rsp_rdata_a [2];

  assign bus0.req_valid  = req_valid_a[0];
  assign bus0.req_we     = req_we_a[0];
  assign bus0.req_funct3 = req_f3_a[0];
  assign bus0.req_addr   = req_addr_a[0];
  assign bus0.req_wdata  = req_wdata_a[0];
  assign bus0.rsp_ready  = rsp_ready_a[0];
  assign req_ready_a[0]  = bus0.req_ready;
  assign rsp_valid_a[0]  = bus0.rsp_valid;
  assign rsp_err_a[0]    = bus0.rsp_err;
  assign rsp_rdata_a[0]  = bus0.rsp_rdata;

  assign bus1.req_valid  = req_valid_a[1];
  assign bus1.req_we     = req_we_a[1];
  assign bus1.req_funct3 = req_f3_a[1];
  assign bus1.req_addr   = req_addr_a[1];
  assign bus1.req_wdata  = req_wdata_a[1];
  assign bus1.rsp_ready  = rsp_ready_a[1];
  assign req_ready_a[1]  = bus1.req_ready;
  assign rsp_valid_a[1]  = bus1.rsp_valid;
  assign rsp_err_a[1]    = bus1.rsp_err;
  assign rsp_rdata_a[1]  = bus1.rsp_rdata;

  logic [7:0] model_mem [2][MW*4];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input int sel);
    return (sel == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int ws_of(input int sel);
    return (sel == 0) ? WS0 : WS1;
  endfunction

  // Reference: the memory is a flat byte array; an access is a run of bytes.
  task automatic model_access(input int sel, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rd, output logic er);
    int          size;
    logic [31:0] off, v, t;
    er = 1'b0; rd = 32'd0; size = 1;
    if (we) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: er = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    er = 1'b1;
      endcase
    end
    off = addr - base_of(sel);
    if (addr < base_of(sel) || off >= 32'(MW*4)) er = 1'b1;
    if (!er && (off % 32'(size)) != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      er = 1'b1;
`else
      off = off - (off % 32'(size));
`endif
    end
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) begin
          t = wdata >> (8*i);
          model_mem[sel][off + 32'(i)] = t[7:0];
        end
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(model_mem[sel][off + 32'(i)]) << (8*i));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  task automatic txn(input int sel, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     output logic [31:0] rd, output logic er);
    int          n;
    logic [31:0] erd;
    logic        eer;
    model_access(sel, we, f3, addr, wdata, erd, eer);
    @(negedge clk);
    req_valid_a[sel] = 1'b1;
    req_we_a[sel]    = we;
    req_f3_a[sel]    = f3;
    req_addr_a[sel]  = addr;
    req_wdata_a[sel] = wdata;
    n = 0;
    while (!req_ready_a[sel] && n < 20) begin @(negedge clk); n++; end
    check_eq("accept_in_time", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    // Scramble the request fields: the block must ignore them now.
    req_valid_a[sel] = 1'b0;
    req_we_a[sel]    = 1'($urandom);
    req_f3_a[sel]    = 3'($urandom);
    req_addr_a[sel]  = $urandom;
    req_wdata_a[sel] = $urandom;
    n = 1;
    while (!rsp_valid_a[sel] && n < 40) begin @(posedge clk); #1; n++; end
    check_eq("latency", 32'(n), 32'(ws_of(sel) + 2));
    rd = rsp_rdata_a[sel];
    er = rsp_err_a[sel];
    check_eq("rdata", rd, erd);
    check_eq("err", 32'(er), 32'(eer));
    check_eq("busy_ready_low", 32'(req_ready_a[sel]), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(rsp_valid_a[sel]), 32'd1);
      check_eq("hold_rdata", rsp_rdata_a[sel], erd);
      check_eq("hold_ready_low", 32'(req_ready_a[sel]), 32'd0);
    end
    rsp_ready_a[sel] = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a[sel] = 1'b0;
    check_eq("rsp_dropped", 32'(rsp_valid_a[sel]), 32'd0);
    check_eq("back_to_idle", 32'(req_ready_a[sel]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout after %0d checks", n_checks);
    $fatal(1);
  end

  logic [31:0] rd;
  logic        er;
  logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    int          sel, n;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;

    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid_a[s] = 1'b0; req_we_a[s] = 1'b0; req_f3_a[s] = 3'd0;
      req_addr_a[s] = 32'd0; req_wdata_a[s] = 32'd0; rsp_ready_a[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check_eq("reset_req_ready", 32'(req_ready_a[s]), 32'd0);
      check_eq("reset_rsp_valid", 32'(rsp_valid_a[s]), 32'd0);
      check_eq("reset_rsp_rdata", rsp_rdata_a[s], 32'd0);
      check_eq("reset_rsp_err", 32'(rsp_err_a[s]), 32'd0);
    end
    @(negedge clk); rst = 1'b1;

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < MW; w++)
        txn(s, 1'b1, 3'd2, base_of(s) + 32'(4*w), $urandom, 0, rd, er);

    // Directed sizing sequence on the zero-wait instance.
    txn(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, rd, er);
    txn(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    check_eq("lw_after_sw", rd, 32'hDEAD_BEEF);
    txn(0, 1'b1, 3'd0, 32'h11, 32'h0000_00A5, 0, rd, er);
    check_eq("sb_rdata_zero", rd, 32'd0);
    txn(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    check_eq("lw_after_sb", rd, 32'hDEAD_A5EF);
    txn(0, 1'b0, 3'd0, 32'h11, 32'd0, 0, rd, er);
    check_eq("lb_sext", rd, 32'hFFFF_FFA5);
    txn(0, 1'b0, 3'd4, 32'h11, 32'd0, 0, rd, er);
    check_eq("lbu_zext", rd, 32'h0000_00A5);
    txn(0, 1'b0, 3'd5, 32'h12, 32'd0, 0, rd, er);
    check_eq("lhu_zext", rd, 32'h0000_DEAD);
    txn(0, 1'b0, 3'd2, 32'(MW*4), 32'd0, 0, rd, er);
    check_eq("oob_load_err", 32'(er), 32'd1);
    check_eq("oob_load_rdata", rd, 32'd0);
    txn(0, 1'b0, 3'd3, 32'h10, 32'd0, 0, rd, er);
    check_eq("bad_f3_err", 32'(er), 32'd1);
    txn(0, 1'b1, 3'd2, 32'(MW*4), 32'hFFFF_FFFF, 0, rd, er);
    check_eq("oob_store_err", 32'(er), 32'd1);
    txn(0, 1'b0, 3'd2, 32'h0, 32'd0, 0, rd, er);
    txn(0, 1'b1, 3'd1, 32'h13, 32'h0000_CAFE, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check_eq("sh_mis_err", 32'(er), 32'd1);
    txn(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    check_eq("sh_mis_nowrite", rd, 32'hDEAD_A5EF);
`else
    check_eq("sh_mis_err", 32'(er), 32'd0);
    txn(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    check_eq("sh_mis_aligned", rd, 32'hCAFE_A5EF);
`endif

    // Wait-state instance: back-pressure on the response and underflow.
    txn(1, 1'b1, 3'd2, BASE1 + 32'h8, 32'h1234_5678, 0, rd, er);
    txn(1, 1'b0, 3'd2, BASE1 + 32'h8, 32'd0, 5, rd, er);
    check_eq("stall_rdata", rd, 32'h1234_5678);
    txn(1, 1'b0, 3'd2, BASE1 - 32'd4, 32'd0, 0, rd, er);
    check_eq("underflow_err", 32'(er), 32'd1);

    // Reset during WAIT drops the pending store.
    txn(1, 1'b1, 3'd2, BASE1 + 32'h20, 32'h1111_1111, 0, rd, er);
    @(negedge clk);
    req_valid_a[1] = 1'b1; req_we_a[1] = 1'b1; req_f3_a[1] = 3'd2;
    req_addr_a[1] = BASE1 + 32'h20; req_wdata_a[1] = 32'h2222_2222;
    @(posedge clk); #1;
    req_valid_a[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check_eq("abort_wait_valid", 32'(rsp_valid_a[1]), 32'd0);
    check_eq("abort_wait_ready", 32'(req_ready_a[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    txn(1, 1'b0, 3'd2, BASE1 + 32'h20, 32'd0, 0, rd, er);
    check_eq("abort_no_write", rd, 32'h1111_1111);

    // Reset while a response is pending clears it immediately.
    @(negedge clk);
    req_valid_a[1] = 1'b1; req_we_a[1] = 1'b0; req_f3_a[1] = 3'd2;
    req_addr_a[1] = BASE1 + 32'h20;
    @(posedge clk); #1;
    req_valid_a[1] = 1'b0;
    n = 0;
    while (!rsp_valid_a[1] && n < 40) begin @(posedge clk); #1; n++; end
    check_eq("resp_reached", 32'(rsp_valid_a[1]), 32'd1);
    rst = 1'b0; #1;
    check_eq("abort_resp_valid", 32'(rsp_valid_a[1]), 32'd0);
    check_eq("abort_resp_rdata", rsp_rdata_a[1], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 1));
      we  = 1'($urandom);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ld_f3[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = base_of(sel) - 32'($urandom_range(1, 16));
        2:       addr = base_of(sel) + 32'(MW*4) + 32'($urandom_range(0, 15));
        default: addr = base_of(sel) + 32'($urandom_range(0, MW*4 - 1));
      endcase
      txn(sel, we, f3, addr, $urandom, int'($urandom_range(0, 2)), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
